sp_rr_pkt_arbiter: RTL



---
 rtl/sp_rr_pkt_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sp_rr_pkt_arbiter.sv
// rtl/sp_rr_pkt_arbiter.sv - N-to-1 valid/ready arbiter with packet lock and registered output
module sp_rr_pkt_arbiter #(
    parameter int REQ_NUMB      = 4,
    parameter int ID_BITWIDTH   = 2,
    parameter int DATA_BITWIDTH = 10,
    parameter int ARB_MODE      = 0,
    parameter int PKT_MODE      = 1
) (
    input  logic                              sys_clk,
    input  logic                              rst_n,
    input  logic [REQ_NUMB-1:0]               RxVld,
    input  logic [REQ_NUMB*DATA_BITWIDTH-1:0] RxData,
    input  logic [REQ_NUMB-1:0]               RxLast,
    output logic [REQ_NUMB-1:0]               RxRdy,
    output logic                              TxVld,
    output logic [DATA_BITWIDTH-1:0]          TxData,
    output logic                              TxLast,
    output logic [ID_BITWIDTH-1:0]            TxPortId,
    input  logic                              TxRdy
);

    localparam int PTR_W = $clog2(REQ_NUMB);

    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic                     lock_q, lock_d;
    logic [PTR_W-1:0]         lock_id_q, lock_id_d;
    logic                     tx_vld_q, tx_vld_d;
    logic [DATA_BITWIDTH-1:0] tx_data_q, tx_data_d;
    logic                     tx_last_q, tx_last_d;
    logic [ID_BITWIDTH-1:0]   tx_port_id_q, tx_port_id_d;

    logic [DATA_BITWIDTH-1:0] rx_data_arr [REQ_NUMB];
    logic                     sel_vld;
    logic [PTR_W-1:0]         sel_idx;
    logic [DATA_BITWIDTH-1:0] sel_data;
    logic                     sel_last;
    logic [REQ_NUMB-1:0]      gnt;
    logic                     ld;
    logic                     xfer;
    int                       idx;

    for (genvar p = 0; p < REQ_NUMB; p++) begin : g_unpack
        assign rx_data_arr[p] = RxData[p*DATA_BITWIDTH +: DATA_BITWIDTH];
    end

    // Winner selection: locked port only, else lowest index or first valid at/after ptr.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        if (PKT_MODE != 0 && lock_q) begin
            sel_vld = RxVld[lock_id_q];
            sel_idx = lock_id_q;
        end else if (ARB_MODE == 0) begin
            for (int i = REQ_NUMB - 1; i >= 0; i--) begin
                if (RxVld[PTR_W'(i)]) begin
                    sel_vld = 1'b1;
                    sel_idx = PTR_W'(i);
                end
            end
        end else begin
            for (int k = REQ_NUMB - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= REQ_NUMB) begin
                    idx = idx - REQ_NUMB;
                end
                if (RxVld[PTR_W'(idx)]) begin
                    sel_vld = 1'b1;
                    sel_idx = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (sel_vld) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    assign sel_data = rx_data_arr[sel_idx];
    assign sel_last = RxLast[sel_idx];
    assign ld       = !tx_vld_q || TxRdy;
    assign xfer     = ld && sel_vld;
    assign RxRdy    = ld ? gnt : '0;

    always_comb begin
        ptr_d        = ptr_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        tx_vld_d     = tx_vld_q;
        tx_data_d    = tx_data_q;
        tx_last_d    = tx_last_q;
        tx_port_id_d = tx_port_id_q;
        if (ld) begin
            tx_vld_d = xfer;
            if (xfer) begin
                tx_data_d    = sel_data;
                tx_last_d    = sel_last;
                tx_port_id_d = ID_BITWIDTH'(sel_idx);
            end
        end
        if (xfer) begin
            // In packet mode the pointer only advances at packet boundaries.
            if (PKT_MODE == 0 || sel_last) begin
                ptr_d = (sel_idx == PTR_W'(REQ_NUMB - 1)) ? '0 : sel_idx + PTR_W'(1);
            end
            if (PKT_MODE != 0) begin
                lock_d    = !sel_last;
                lock_id_d = sel_idx;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            tx_vld_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_last_q    <= 1'b0;
            tx_port_id_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            tx_vld_q     <= tx_vld_d;
            tx_data_q    <= tx_data_d;
            tx_last_q    <= tx_last_d;
            tx_port_id_q <= tx_port_id_d;
        end
    end

    assign TxVld    = tx_vld_q;
    assign TxData   = tx_data_q;
    assign TxLast   = tx_last_q;
    assign TxPortId = tx_port_id_q;

endmodule
